// File: rtl/plab2_proc_dmem_responder.sv
// Memory-side responder: val/rdy word requests against an internal array, in-order responses via a small queue.
// Optional macro PLAB2_DMEM_DOMAIN_CHECK_EN rejects low-domain accesses to the high partition at the top of the array.
module plab2_proc_dmem_responder #(
  parameter int p_addr_nbits   = 8,
  parameter int p_queue_depth  = 2,
  parameter int p_num_hi_words = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        domain,
  input  logic        memreq_val,
  output logic        memreq_rdy,
  input  logic        memreq_msg_type,
  input  logic [31:0] memreq_msg_addr,
  input  logic [31:0] memreq_msg_data,
  output logic        memresp_val,
  input  logic        memresp_rdy,
  output logic        memresp_msg_type,
  output logic [31:0] memresp_msg_data,
  output logic        memresp_msg_err
);

  localparam int c_num_words = 1 << p_addr_nbits;

  logic [31:0] mem_r [c_num_words];

  // Queue storage is sized for the largest legal depth so 2-bit pointers index it exactly.
  logic        q_type_r [4];
  logic [31:0] q_data_r [4];
  logic        q_err_r  [4];
  logic [1:0]  head_r;
  logic [1:0]  tail_r;
  logic [2:0]  count_r;
  logic        rdy_r;
  logic        val_r;

  logic                    req_fire_s;
  logic                    resp_fire_s;
  logic [p_addr_nbits-1:0] word_idx_s;
  logic                    oor_s;
  logic                    hi_deny_s;
  logic                    resp_err_s;
  logic [31:0]             resp_data_s;
  logic [2:0]              count_next_s;

  logic unused_bits_s;
  assign unused_bits_s = &{1'b0, domain, memreq_msg_addr[1:0]};

`ifdef PLAB2_DMEM_DOMAIN_CHECK_EN
  localparam logic [p_addr_nbits-1:0] c_hi_base = p_addr_nbits'(c_num_words - p_num_hi_words);
`else
  localparam int unused_hi_words = p_num_hi_words;
`endif

  function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
    if (ptr == 2'(p_queue_depth - 1)) begin
      return 2'd0;
    end else begin
      return ptr + 2'd1;
    end
  endfunction

  // Request decode, read sampling and queue occupancy update.
  always_comb begin
    req_fire_s  = memreq_val && rdy_r;
    resp_fire_s = val_r && memresp_rdy;
    word_idx_s  = memreq_msg_addr[p_addr_nbits+1:2];
    oor_s       = |(memreq_msg_addr >> (p_addr_nbits + 2));
`ifdef PLAB2_DMEM_DOMAIN_CHECK_EN
    hi_deny_s   = (domain == 1'b0) && (word_idx_s >= c_hi_base);
`else
    hi_deny_s   = 1'b0;
`endif
    resp_err_s  = oor_s || hi_deny_s;
    if (resp_err_s || memreq_msg_type) begin
      resp_data_s = 32'd0;
    end else begin
      resp_data_s = mem_r[word_idx_s];
    end
    case ({req_fire_s, resp_fire_s})
      2'b10:   count_next_s = count_r + 3'd1;
      2'b01:   count_next_s = count_r - 3'd1;
      default: count_next_s = count_r;
    endcase
  end

  // Array contents survive reset; rejected writes never commit.
  always_ff @(posedge clk) begin
    if (req_fire_s && memreq_msg_type && !resp_err_s) begin
      mem_r[word_idx_s] <= memreq_msg_data;
    end
  end

  // Response queue; rdy and val are registered from the next occupancy so there is no bypass.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_r  <= 2'd0;
      tail_r  <= 2'd0;
      count_r <= 3'd0;
      rdy_r   <= 1'b0;
      val_r   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        q_type_r[i] <= 1'b0;
        q_data_r[i] <= 32'd0;
        q_err_r[i]  <= 1'b0;
      end
    end else begin
      if (req_fire_s) begin
        q_type_r[tail_r] <= memreq_msg_type;
        q_data_r[tail_r] <= resp_data_s;
        q_err_r[tail_r]  <= resp_err_s;
        tail_r           <= ptr_inc(tail_r);
      end
      if (resp_fire_s) begin
        head_r <= ptr_inc(head_r);
      end
      count_r <= count_next_s;
      rdy_r   <= (count_next_s < 3'(p_queue_depth));
      val_r   <= (count_next_s != 3'd0);
    end
  end

  assign memreq_rdy       = rdy_r;
  assign memresp_val      = val_r;
  assign memresp_msg_type = q_type_r[head_r];
  assign memresp_msg_data = q_data_r[head_r];
  assign memresp_msg_err  = q_err_r[head_r];

endmodule

// File: doc/plab2_proc_dmem_responder.md
Name: plab2_proc_dmem_responder

Overview:
- Memory-side responder for the pipelined processor's data and instruction memory ports.
- Accepts val/rdy memory requests (read/write, 32-bit word), performs the access on an internal word array, and returns in-order responses through a small response queue.
- Every data-carrying signal is labelled by the `domain` input, matching the processor datapath.
- Used in place of the test memory for processor-level simulation and security checking.

Parameters:
- p_addr_nbits, 8: word-index width; the array holds 2^p_addr_nbits 32-bit words.
- p_queue_depth, 2: response queue entries (legal values 1..4).
- p_num_hi_words, 64: size of the high-domain partition at the top of the array. Only used with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- domain  in  1  security domain of the current requester (0 = low, 1 = high).
- memreq_val  in  1  request valid.
- memreq_rdy  out  1  responder can accept a request.
- memreq_msg_type  in  1  0 = read, 1 = write.
- memreq_msg_addr  in  32  byte address.
- memreq_msg_data  in  32  write data; ignored for reads.
- memresp_val  out  1  response valid.
- memresp_rdy  in  1  consumer accepts the response.
- memresp_msg_type  out  1  echoes the request type.
- memresp_msg_data  out  32  read data; 0 for writes.
- memresp_msg_err  out  1  access was rejected.

Behaviour:
- Reset (asserted low, asynchronous):
  - queue count and pointers go to 0.
  - memresp_val = 0; memresp_msg_type/data/err = 0.
  - memreq_rdy = 0 while reset is asserted; it rises the first cycle after deassertion.
  - Array contents are not cleared.
- Accept: request fires when memreq_val && memreq_rdy at a rising edge.
  - memreq_rdy = (count < p_queue_depth).
  - There is no enqueue/dequeue bypass: when the queue is full and dequeues in the same cycle, rdy stays 0 in that cycle.
- Address decode:
  - word index = addr[p_addr_nbits+1:2]; addr[1:0] is ignored (no alignment error).
  - Out of range when any of addr[31:p_addr_nbits+2] is nonzero. Response then has err = 1 and data = 0; a write is dropped.
- Access at accept:
  - A write commits to the array on the accepting edge.
  - A read samples the array combinationally in the accepting cycle. It therefore sees all earlier accepted writes, but not a write in the same cycle (one request per cycle, so no conflict).
- Response latency: a request accepted at edge t produces memresp_val = 1 from cycle t+1 at the earliest. Responses are strictly in order.
- Queue: circular buffer of {type, data, err}.
  - Head drives memresp_* directly; memresp_val = (count != 0).
  - Pointers wrap modulo p_queue_depth.
  - Simultaneous enqueue and dequeue leaves count unchanged.
  - Outputs hold stable while memresp_val && !memresp_rdy.
- Mid-operation reset discards all queued responses. Writes already committed remain in the array.
- Labels: request/response payload ports and queue storage are {Data domain}; val/rdy/type are {Ctrl domain}.

Optional Feature:
- Macro: PLAB2_DMEM_DOMAIN_CHECK_EN.
- Defined:
  - Word indices >= 2^p_addr_nbits - p_num_hi_words form the high partition.
  - A request with domain = 0 that targets the high partition gets err = 1 and data = 0, and a write is dropped.
  - domain = 1 may access any word.
  - The error is produced with the same latency as a normal response.
- Undefined: no partition check; err is asserted only for out-of-range addresses, and p_num_hi_words is unused.

Test Plan:
- Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 back-to-back with memresp_rdy = 1 → responses in order: {type 1, data 0, err 0}, then {type 0, data 0xDEADBEEF, err 0} one cycle apart.
- Hold memresp_rdy = 0 and issue 3 reads with p_queue_depth = 2 → memreq_rdy drops after 2 accepts. Raise rdy → 2 responses drain, then the third request is accepted.
- Read 0x0000_0400 with p_addr_nbits = 8 → err = 1, data = 0. A following read of 0x0 returns the value previously written there.
- Pulse reset low with 2 responses queued → memresp_val = 0 immediately (asynchronous). After release, a read of the earlier-written address still returns the written data.
- With PLAB2_DMEM_DOMAIN_CHECK_EN: domain = 0 write of 0x1234 to word 250 → err = 1. A domain = 1 read of word 250 returns the old value. A domain = 1 write of 0x5678 to word 250, followed by a domain = 1 read, returns 0x5678 with err = 0.
- Continuous read stream with memresp_rdy = 1 → throughput of one response per cycle; count never exceeds 1.
